ntt8_lane_engine: RTL and testbench
===================================

Name: ntt8_lane_engine

Overview:
- Single-pass modular (number-theoretic) transform engine over 8 data lanes. Input data are residues modulo a run-time modulus q.
- Per cycle it does one of two things:
  - pointwise-multiplies the 8 lanes by 8 coefficients, or
  - runs a radix-2 decimation-in-frequency NTT/INTT of size 2, 4 or 8 on independent lane groups.
- Result is registered and presented as memory write data for the surrounding transform datapath.

Parameters:
- DATA_WIDTH, default 32: width of every data word, coefficient and the modulus.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset. Synchronous, active-high despite the name: when 1 at a rising edge, all registers clear.
- FFT_0..FFT_7  in  DATA_WIDTH each  input lanes; each must be < modular.
- modular  in  DATA_WIDTH  modulus q; must be odd and >= 3.
- point  in  3  transform size select, log2 N; see Behaviour.
- inverse  in  1  0 = forward NTT, 1 = inverse NTT.
- FFT_LAST_STAGE  in  1  1 = reorder result from bit-reversed to natural order within each group.
- POINTWISE_COEF_0..7  in  DATA_WIDTH each  coefficient k = ω8^k mod q (COEF_0 = 1). Also used as pointwise multipliers.
- mem_IN_0..mem_IN_7  out  DATA_WIDTH each  registered result lanes.
- ctrl_sig  out  3  registered effective log2 N of the presented result (0..3).

Behaviour:
- Reset: all mem_IN_* = 0, ctrl_sig = 0.
- Latency: inputs are sampled every rising edge with rst_n = 0; results appear on the outputs after that edge (1-cycle latency, no handshake, full throughput).
- Effective size: p = point clamped to 3 (point 4..7 behaves as 3). ctrl_sig <= p.
- p = 0, pointwise mode: mem_IN_i = FFT_i · COEF_i mod q. inverse and FFT_LAST_STAGE are ignored.
- p = 1..3, transform mode:
  - N = 2^p; lanes form 8/N independent groups of N consecutive lanes.
  - DIF stages run with half-size h = N/2, N/4, ..., 1.
  - For each pair (j, j+h) in a block, with j the offset within the block, 0..h-1:
    - a' = a + b mod q
    - b' = (a − b mod q) · W mod q
    - forward: W = COEF_{j·4/h}
    - inverse: W = COEF_{(8 − j·4/h) mod 8}
  - Inverse only: after the last stage, every lane is multiplied by N^-1 by halving p times. Halving rule: x even → x>>1; x odd → (x+q)>>1.
  - Natural output order: position k holds X_k.
  - FFT_LAST_STAGE = 0: position k holds X_bitrev_p(k) (raw DIF order).
  - FFT_LAST_STAGE = 1: natural order within each group.
- Arithmetic rules:
  - Modular add: s = a + b in DATA_WIDTH+1 bits; if s >= q then s − q.
  - Modular subtract: a >= b ? a − b : a + q − b.
  - Multiply: full 2·DATA_WIDTH product, then reduce mod q.
  - All lane results are in [0, q).
- Mid-operation changes: point, inverse, modular and coefficients may change every cycle. Each cycle's result depends only on that cycle's inputs.
- Reset asserted mid-stream: the next edge clears the outputs; any in-flight input is discarded.

Decomposition:
- Shared package:
  - DATA_WIDTH default
  - point encoding constants: PT_POINTWISE = 0, MAX_LOG2N = 3
  - twiddle index function j·4/h and its inverse mapping
  - bit-reverse helper
- Sub-module mod_butterfly: inputs a, b, W, q; outputs (a+b mod q, (a−b)·W mod q). Instantiate 4 per stage × 3 stages, plus halving/reorder logic in the top.

Test Plan (all with q = 55822321, inputs 10,2,32,44,5,67,7,6, COEF all 1 unless stated):
- Reset: rst_n = 1 for one edge → all mem_IN = 0, ctrl_sig = 0.
- Forward 2-point:
  - Stimulus: point = 1, inverse = 0.
  - Required: mem_IN = 12, 8, 76, 55822309, 72, 55822259, 13, 1; ctrl_sig = 1.
- Forward 4-point, bit-reversed:
  - Stimulus: point = 2, FFT_LAST_STAGE = 0.
  - Required: lanes 0..3 = 88, 55822317, 55822257, 20.
  - Same stimulus with FFT_LAST_STAGE = 1 → lanes 0..3 = 88, 55822257, 55822317, 20.
- Clamp:
  - Stimulus: point = 5 and point = 4.
  - Required: both outputs equal point = 3; lane 0 = 173; ctrl_sig = 3.
- Inverse round trip:
  - Stimulus: inverse = 1, point = 1, inputs 12, 8, 76, 55822309, 72, 55822259, 13, 1.
  - Required: 10, 2, 32, 44, 5, 67, 7, 6.
  - Repeat forward→inverse for point 2 and 3 with true ω8 powers; each must return the original inputs.
- Pointwise:
  - Stimulus: point = 0, COEF_i = i + 2.
  - Required: 20, 6, 128, 220, 30, 469, 56, 54; inverse toggling has no effect.

Source files
------------

// File: rtl/ntt8_lane_engine_pkg.sv
// Shared constants and index helpers for the 8-lane NTT engine.
package ntt8_lane_engine_pkg;

    localparam int         DATA_WIDTH_DEF = 32;
    localparam int         NUM_LANES      = 8;
    localparam logic [1:0] PT_POINTWISE   = 2'd0;
    localparam int         MAX_LOG2N      = 3;

    // Forward twiddle exponent (in units of omega8) for offset j of a block with half-size h.
    function automatic logic [2:0] tw_idx(input int j, input int h);
        return 3'((j * 4) / h);
    endfunction

    // Inverse transform uses the conjugate power: omega8^(8-k) mod 8.
    function automatic logic [2:0] tw_idx_inv(input logic [2:0] idx);
        return 3'(4'd8 - {1'b0, idx});
    endfunction

    // Maps a lane to the lane holding its bit-reversed partner within its 2^p group.
    function automatic logic [2:0] bitrev_lane(input logic [2:0] l, input logic [1:0] p);
        case (p)
            2'd2:    return {l[2], l[0], l[1]};
            2'd3:    return {l[0], l[1], l[2]};
            default: return l;
        endcase
    endfunction

endpackage

// File: rtl/ntt8_lane_engine_mod_butterfly.sv
// DIF butterfly: (a+b mod q, (a-b mod q)*w mod q). Purely combinational.
module ntt8_lane_engine_mod_butterfly #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] w,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] sum,
    output logic [DATA_WIDTH-1:0] dif
);

    logic [DATA_WIDTH:0]     s_full;
    logic [DATA_WIDTH-1:0]   d;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [2*DATA_WIDTH-1:0] rem;

    // Modular add with one conditional subtract, modular subtract, then full-width product reduction.
    always_comb begin
        s_full = {1'b0, a} + {1'b0, b};
        sum    = (s_full >= {1'b0, q}) ? DATA_WIDTH'(s_full - {1'b0, q}) : DATA_WIDTH'(s_full);
        // a < b case: a - b + q fits in DATA_WIDTH bits because the true value is below q.
        d      = (a >= b) ? (a - b) : (a + q - b);
        prod   = {{DATA_WIDTH{1'b0}}, d} * {{DATA_WIDTH{1'b0}}, w};
        rem    = prod % {{DATA_WIDTH{1'b0}}, q};
        dif    = DATA_WIDTH'(rem);
    end

endmodule

// File: rtl/ntt8_lane_engine.sv
// Single-pass 8-lane modular engine: pointwise multiply or size-2/4/8 DIF NTT/INTT per group,
// with optional bit-reverse reordering; result registered as memory write data.
module ntt8_lane_engine
    import ntt8_lane_engine_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] FFT_0,
    input  logic [DATA_WIDTH-1:0] FFT_1,
    input  logic [DATA_WIDTH-1:0] FFT_2,
    input  logic [DATA_WIDTH-1:0] FFT_3,
    input  logic [DATA_WIDTH-1:0] FFT_4,
    input  logic [DATA_WIDTH-1:0] FFT_5,
    input  logic [DATA_WIDTH-1:0] FFT_6,
    input  logic [DATA_WIDTH-1:0] FFT_7,
    input  logic [DATA_WIDTH-1:0] modular,
    input  logic [2:0]            point,
    input  logic                  inverse,
    input  logic                  FFT_LAST_STAGE,
    input  logic [DATA_WIDTH-1:0] POINTWISE_COEF_0,
    input  logic [DATA_WIDTH-1:0] POINTWISE_COEF_1,
    input  logic [DATA_WIDTH-1:0] POINTWISE_COEF_2,
    input  logic [DATA_WIDTH-1:0] POINTWISE_COEF_3,
    input  logic [DATA_WIDTH-1:0] POINTWISE_COEF_4,
    input  logic [DATA_WIDTH-1:0] POINTWISE_COEF_5,
    input  logic [DATA_WIDTH-1:0] POINTWISE_COEF_6,
    input  logic [DATA_WIDTH-1:0] POINTWISE_COEF_7,
    output logic [DATA_WIDTH-1:0] mem_IN_0,
    output logic [DATA_WIDTH-1:0] mem_IN_1,
    output logic [DATA_WIDTH-1:0] mem_IN_2,
    output logic [DATA_WIDTH-1:0] mem_IN_3,
    output logic [DATA_WIDTH-1:0] mem_IN_4,
    output logic [DATA_WIDTH-1:0] mem_IN_5,
    output logic [DATA_WIDTH-1:0] mem_IN_6,
    output logic [DATA_WIDTH-1:0] mem_IN_7,
    output logic [2:0]            ctrl_sig
);

    function automatic logic [DATA_WIDTH-1:0] mul_mod(input logic [DATA_WIDTH-1:0] x,
                                                      input logic [DATA_WIDTH-1:0] y,
                                                      input logic [DATA_WIDTH-1:0] m);
        logic [2*DATA_WIDTH-1:0] prod;
        prod = {{DATA_WIDTH{1'b0}}, x} * {{DATA_WIDTH{1'b0}}, y};
        return DATA_WIDTH'(prod % {{DATA_WIDTH{1'b0}}, m});
    endfunction

    // Multiply by 2^-1 mod odd m: odd values get m added first so the shift is exact.
    function automatic logic [DATA_WIDTH-1:0] halve(input logic [DATA_WIDTH-1:0] x,
                                                    input logic [DATA_WIDTH-1:0] m);
        logic [DATA_WIDTH:0] t;
        t = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
        return DATA_WIDTH'(t >> 1);
    endfunction

    logic [1:0]            p_eff;
    logic [2:0]            src;
    logic [DATA_WIDTH-1:0] coef  [NUM_LANES];
    logic [DATA_WIDTH-1:0] stg   [MAX_LOG2N+1][NUM_LANES];
    logic [DATA_WIDTH-1:0] hv    [MAX_LOG2N+1][NUM_LANES];
    logic [DATA_WIDTH-1:0] nxt   [NUM_LANES];
    logic [DATA_WIDTH-1:0] res_q [NUM_LANES];

    assign p_eff = (point > 3'(MAX_LOG2N)) ? 2'(MAX_LOG2N) : point[1:0];

    assign stg[0][0] = FFT_0;  assign coef[0] = POINTWISE_COEF_0;
    assign stg[0][1] = FFT_1;  assign coef[1] = POINTWISE_COEF_1;
    assign stg[0][2] = FFT_2;  assign coef[2] = POINTWISE_COEF_2;
    assign stg[0][3] = FFT_3;  assign coef[3] = POINTWISE_COEF_3;
    assign stg[0][4] = FFT_4;  assign coef[4] = POINTWISE_COEF_4;
    assign stg[0][5] = FFT_5;  assign coef[5] = POINTWISE_COEF_5;
    assign stg[0][6] = FFT_6;  assign coef[6] = POINTWISE_COEF_6;
    assign stg[0][7] = FFT_7;  assign coef[7] = POINTWISE_COEF_7;

    // DIF stages with h = 4, 2, 1. A stage only runs when h < N, otherwise it passes data through,
    // so smaller transforms simply start at a later stage. Twiddles depend on h and j only.
    for (genvar s = 0; s < MAX_LOG2N; s++) begin : g_stage
        localparam int H = (NUM_LANES / 2) >> s;
        logic act;
        assign act = (p_eff >= 2'(MAX_LOG2N - s));
        for (genvar m = 0; m < NUM_LANES / 2; m++) begin : g_bf
            localparam int         J   = m % H;
            localparam int         LO  = (m / H) * 2 * H + J;
            localparam int         HI  = LO + H;
            localparam logic [2:0] TW  = tw_idx(J, H);
            localparam logic [2:0] TWI = tw_idx_inv(TW);
            logic [DATA_WIDTH-1:0] w, sum, dif;
            assign w = inverse ? coef[TWI] : coef[TW];
            ntt8_lane_engine_mod_butterfly #(.DATA_WIDTH(DATA_WIDTH)) u_bf (
                .a(stg[s][LO]), .b(stg[s][HI]), .w(w), .q(modular), .sum(sum), .dif(dif)
            );
            assign stg[s+1][LO] = act ? sum : stg[s][LO];
            assign stg[s+1][HI] = act ? dif : stg[s][HI];
        end
    end

    // Inverse scaling by N^-1: p successive halvings.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_hv0
        assign hv[0][l] = stg[MAX_LOG2N][l];
    end
    for (genvar t = 0; t < MAX_LOG2N; t++) begin : g_half
        logic en;
        assign en = inverse && (p_eff > 2'(t));
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            assign hv[t+1][l] = en ? halve(hv[t][l], modular) : hv[t][l];
        end
    end

    // Select pointwise product or (optionally reordered) transform result per lane.
    always_comb begin
        src = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            src = FFT_LAST_STAGE ? bitrev_lane(3'(l), p_eff) : 3'(l);
            if (p_eff == PT_POINTWISE)
                nxt[l] = mul_mod(stg[0][l], coef[l], modular);
            else
                nxt[l] = hv[MAX_LOG2N][src];
        end
    end

    // Output register; rst_n is active-high synchronous clear.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int l = 0; l < NUM_LANES; l++) res_q[l] <= '0;
            ctrl_sig <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) res_q[l] <= nxt[l];
            ctrl_sig <= {1'b0, p_eff};
        end
    end

    assign mem_IN_0 = res_q[0];
    assign mem_IN_1 = res_q[1];
    assign mem_IN_2 = res_q[2];
    assign mem_IN_3 = res_q[3];
    assign mem_IN_4 = res_q[4];
    assign mem_IN_5 = res_q[5];
    assign mem_IN_6 = res_q[6];
    assign mem_IN_7 = res_q[7];

endmodule

// File: tb/tb_ntt8_lane_engine.sv
// Directed bench for ntt8_lane_engine: reset, forward/inverse transforms, clamp, reorder, pointwise.
module tb_ntt8_lane_engine;

    localparam logic [31:0] Q = 32'd55822321;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] fft  [8];
    logic [31:0] coef [8];
    logic [31:0] mem  [8];
    logic [31:0] din  [8];
    logic [31:0] modular;
    logic [2:0]  point;
    logic        inverse;
    logic        fls;
    logic [2:0]  ctrl_sig;
    int          checks = 0;
    int          errors = 0;
    longint unsigned omega = 0;

    ntt8_lane_engine #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .FFT_0(fft[0]), .FFT_1(fft[1]), .FFT_2(fft[2]), .FFT_3(fft[3]),
        .FFT_4(fft[4]), .FFT_5(fft[5]), .FFT_6(fft[6]), .FFT_7(fft[7]),
        .modular(modular), .point(point), .inverse(inverse), .FFT_LAST_STAGE(fls),
        .POINTWISE_COEF_0(coef[0]), .POINTWISE_COEF_1(coef[1]),
        .POINTWISE_COEF_2(coef[2]), .POINTWISE_COEF_3(coef[3]),
        .POINTWISE_COEF_4(coef[4]), .POINTWISE_COEF_5(coef[5]),
        .POINTWISE_COEF_6(coef[6]), .POINTWISE_COEF_7(coef[7]),
        .mem_IN_0(mem[0]), .mem_IN_1(mem[1]), .mem_IN_2(mem[2]), .mem_IN_3(mem[3]),
        .mem_IN_4(mem[4]), .mem_IN_5(mem[5]), .mem_IN_6(mem[6]), .mem_IN_7(mem[7]),
        .ctrl_sig(ctrl_sig)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_din();
        for (int i = 0; i < 8; i++) fft[i] = din[i];
    endtask

    task automatic coef_ones();
        for (int i = 0; i < 8; i++) coef[i] = 32'd1;
    endtask

    function automatic longint unsigned powmod(input longint unsigned b, input longint unsigned e);
        longint unsigned r = 1;
        longint unsigned x = b % 64'(Q);
        longint unsigned k = e;
        while (k != 0) begin
            if (k[0]) r = (r * x) % 64'(Q);
            x = (x * x) % 64'(Q);
            k = k >> 1;
        end
        return r;
    endfunction

    task automatic test_reset();
        load_din(); coef_ones(); point = 3'd1; inverse = 1'b0; fls = 1'b0;
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem[i] !== 32'd0) begin
                $display("FAIL reset lane%0d: got %0d expected 0", i, mem[i]); errors++;
            end
        end
        checks++;
        if (ctrl_sig !== 3'd0) begin
            $display("FAIL reset ctrl_sig: got %0d expected 0", ctrl_sig); errors++;
        end
        rst_n = 1'b0;
    endtask

    task automatic test_fwd2();
        logic [31:0] exp [8];
        exp = '{32'd12, 32'd8, 32'd76, 32'd55822309, 32'd72, 32'd55822259, 32'd13, 32'd1};
        load_din(); coef_ones(); point = 3'd1; inverse = 1'b0; fls = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem[i] !== exp[i]) begin
                $display("FAIL fwd2 lane%0d: got %0d expected %0d", i, mem[i], exp[i]); errors++;
            end
        end
        checks++;
        if (ctrl_sig !== 3'd1) begin
            $display("FAIL fwd2 ctrl_sig: got %0d expected 1", ctrl_sig); errors++;
        end
    endtask

    task automatic test_fwd4();
        logic [31:0] raw [8];
        logic [31:0] nat [8];
        raw = '{32'd88, 32'd55822317, 32'd55822257, 32'd20, 32'd85, 32'd55822260, 32'd59, 32'd55822258};
        nat = '{32'd88, 32'd55822257, 32'd55822317, 32'd20, 32'd85, 32'd59, 32'd55822260, 32'd55822258};
        load_din(); coef_ones(); point = 3'd2; inverse = 1'b0; fls = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem[i] !== raw[i]) begin
                $display("FAIL fwd4_bitrev lane%0d: got %0d expected %0d", i, mem[i], raw[i]); errors++;
            end
        end
        fls = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem[i] !== nat[i]) begin
                $display("FAIL fwd4_natural lane%0d: got %0d expected %0d", i, mem[i], nat[i]); errors++;
            end
        end
        checks++;
        if (ctrl_sig !== 3'd2) begin
            $display("FAIL fwd4 ctrl_sig: got %0d expected 2", ctrl_sig); errors++;
        end
    endtask

    // Raw-order 8-point result for the default vector with unit twiddles.
    task automatic test_clamp();
        logic [31:0] exp [8];
        logic [2:0]  pts [3];
        exp = '{32'd173, 32'd55822256, 32'd55822316, 32'd55822278,
                32'd3, 32'd57, 32'd55822198, 32'd83};
        pts = '{3'd5, 3'd4, 3'd3};
        load_din(); coef_ones(); inverse = 1'b0; fls = 1'b0;
        for (int k = 0; k < 3; k++) begin
            point = pts[k];
            step();
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (mem[i] !== exp[i]) begin
                    $display("FAIL clamp_p%0d lane%0d: got %0d expected %0d", pts[k], i, mem[i], exp[i]);
                    errors++;
                end
            end
            checks++;
            if (ctrl_sig !== 3'd3) begin
                $display("FAIL clamp_p%0d ctrl_sig: got %0d expected 3", pts[k], ctrl_sig); errors++;
            end
        end
    endtask

    task automatic test_inverse2();
        logic [31:0] fin [8];
        fin = '{32'd12, 32'd8, 32'd76, 32'd55822309, 32'd72, 32'd55822259, 32'd13, 32'd1};
        for (int i = 0; i < 8; i++) fft[i] = fin[i];
        coef_ones(); point = 3'd1; inverse = 1'b1; fls = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem[i] !== din[i]) begin
                $display("FAIL inv2 lane%0d: got %0d expected %0d", i, mem[i], din[i]); errors++;
            end
        end
    endtask

    task automatic set_omega_coefs();
        for (int k = 0; k < 8; k++) coef[k] = 32'(powmod(omega, 64'(k)));
    endtask

    // Unit impulse at lane 1 transforms to omega^k (natural order) within the group.
    task automatic test_impulse();
        set_omega_coefs();
        for (int i = 0; i < 8; i++) fft[i] = 32'd0;
        fft[1] = 32'd1;
        point = 3'd3; inverse = 1'b0; fls = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem[i] !== coef[i]) begin
                $display("FAIL impulse8 lane%0d: got %0d expected %0d", i, mem[i], coef[i]); errors++;
            end
        end
        point = 3'd2;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[i] !== coef[2*i]) begin
                $display("FAIL impulse4 lane%0d: got %0d expected %0d", i, mem[i], coef[2*i]); errors++;
            end
        end
    endtask

    task automatic test_roundtrip(input logic [2:0] pt);
        logic [31:0] fwd [8];
        set_omega_coefs();
        load_din(); point = pt; inverse = 1'b0; fls = 1'b1;
        step();
        for (int i = 0; i < 8; i++) fwd[i] = mem[i];
        for (int i = 0; i < 8; i++) fft[i] = fwd[i];
        inverse = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem[i] !== din[i]) begin
                $display("FAIL roundtrip_p%0d lane%0d: got %0d expected %0d", pt, i, mem[i], din[i]);
                errors++;
            end
        end
    endtask

    task automatic test_pointwise();
        logic [31:0] exp [8];
        exp = '{32'd20, 32'd6, 32'd128, 32'd220, 32'd30, 32'd469, 32'd56, 32'd54};
        load_din();
        for (int i = 0; i < 8; i++) coef[i] = 32'(i + 2);
        point = 3'd0;
        for (int k = 0; k < 2; k++) begin
            inverse = k[0]; fls = k[0];
            step();
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (mem[i] !== exp[i]) begin
                    $display("FAIL pointwise_inv%0d lane%0d: got %0d expected %0d", k, i, mem[i], exp[i]);
                    errors++;
                end
            end
            checks++;
            if (ctrl_sig !== 3'd0) begin
                $display("FAIL pointwise ctrl_sig: got %0d expected 0", ctrl_sig); errors++;
            end
        end
    endtask

    task automatic test_midstream_reset();
        load_din(); coef_ones(); point = 3'd3; inverse = 1'b0; fls = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (mem[0] !== 32'd0 || mem[7] !== 32'd0 || ctrl_sig !== 3'd0) begin
            $display("FAIL midreset_clear: got %0d/%0d/%0d expected 0/0/0", mem[0], mem[7], ctrl_sig);
            errors++;
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (mem[0] !== 32'd173 || ctrl_sig !== 3'd3) begin
            $display("FAIL midreset_resume: got %0d ctrl %0d expected 173 ctrl 3", mem[0], ctrl_sig);
            errors++;
        end
    endtask

    initial begin
        din = '{32'd10, 32'd2, 32'd32, 32'd44, 32'd5, 32'd67, 32'd7, 32'd6};
        modular = Q; point = 3'd0; inverse = 1'b0; fls = 1'b0;
        load_din(); coef_ones();
        for (int g = 2; g < 200 && omega == 0; g++) begin
            longint unsigned w;
            w = powmod(64'(g), (64'(Q) - 1) / 8);
            if (powmod(w, 4) == 64'(Q) - 1) omega = w;
        end
        if (omega == 0) begin
            $display("FAIL omega_search: got none expected an 8th root of unity mod q");
            errors++;
        end

        test_reset();
        test_fwd2();
        test_fwd4();
        test_clamp();
        test_inverse2();
        test_impulse();
        test_roundtrip(3'd2);
        test_roundtrip(3'd3);
        test_pointwise();
        test_midstream_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
